// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and state type for the 3x3 convolution stream engine
package conv_pkg;
   localparam int IMG_N    = 6;
   localparam int K        = 3;
   localparam int W_BITS   = 4;
   localparam int OUT_BITS = 8;
   localparam int OUT_N    = IMG_N - K + 1;
   localparam int CRD_W    = 3;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      OUT,
      DONE
   } conv_state_e;
endpackage

// File: rtl/conv_window_mac.sv
// rtl/conv_window_mac.sv - combinational 3x3 binary-window multiply-accumulate with optional ReLU
module conv_window_mac
   import conv_pkg::*;
#(
   parameter int K        = conv_pkg::K,
   parameter int W_BITS   = conv_pkg::W_BITS,
   parameter int OUT_BITS = conv_pkg::OUT_BITS,
   parameter int RELU     = 1
) (
   input  logic [K*K-1:0]                win,
   input  logic [K*K*W_BITS-1:0]         weights,
   output logic signed [OUT_BITS-1:0]    sum
);
   logic signed [OUT_BITS-1:0] acc;
   logic signed [W_BITS-1:0]   w;

   always_comb begin
      acc = '0;
      w   = '0;
      for (int i = 0; i < K*K; i++) begin
         w = weights[i*W_BITS +: W_BITS];
         // pixels are 1-bit, so each product is either the weight or nothing
         if (win[i]) begin
            acc = acc + {{(OUT_BITS-W_BITS){w[W_BITS-1]}}, w};
         end
      end
      sum = acc;
      if (RELU != 0 && acc[OUT_BITS-1]) begin
         sum = '0;
      end
   end
endmodule

// File: rtl/conv_stream_engine.sv
// rtl/conv_stream_engine.sv - latches a 6x6 binary image and 3x3 kernel, streams the 4x4 valid convolution
module conv_stream_engine
   import conv_pkg::*;
#(
   parameter int IMG_N    = conv_pkg::IMG_N,
   parameter int K        = conv_pkg::K,
   parameter int W_BITS   = conv_pkg::W_BITS,
   parameter int OUT_BITS = conv_pkg::OUT_BITS,
   parameter int RELU     = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [IMG_N*IMG_N-1:0]      image_in,
   input  logic [K*K*W_BITS-1:0]       kernel_in,
   output logic                        busy,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [OUT_BITS-1:0]  out_data,
   output logic [CRD_W-1:0]            out_row,
   output logic [CRD_W-1:0]            out_col,
   output logic                        out_last,
   output logic                        done
);
   localparam int PIX_N = IMG_N * IMG_N;
   localparam int IDX_W = $clog2(PIX_N);
   localparam logic [CRD_W-1:0] LAST_CRD = CRD_W'(IMG_N - K);

   conv_state_e state_q, state_d;
   logic [PIX_N-1:0]          img_q, img_d;
   logic [K*K*W_BITS-1:0]     ker_q, ker_d;
   logic [CRD_W-1:0]          row_q, row_d, col_q, col_d;
   logic signed [OUT_BITS-1:0] data_q, data_d;
   logic                      valid_q, valid_d, last_q, last_d;

   logic [CRD_W-1:0] adv_row, adv_col, sel_row, sel_col;
   logic [IDX_W-1:0] base;
   logic [K*K-1:0]   win;
   logic signed [OUT_BITS-1:0] mac_sum;
   logic             sel_is_last;

   // The MAC always sees the window that will be presented after the next edge.
   always_comb begin
      adv_row = row_q;
      adv_col = col_q + 1'b1;
      if (col_q == LAST_CRD) begin
         adv_col = '0;
         adv_row = row_q + 1'b1;
      end
      sel_row = (state_q == OUT) ? adv_row : row_q;
      sel_col = (state_q == OUT) ? adv_col : col_q;
      sel_is_last = (sel_row == LAST_CRD) && (sel_col == LAST_CRD);
      base = IDX_W'(sel_row) * IDX_W'(IMG_N) + IDX_W'(sel_col);
      win  = '0;
      for (int i = 0; i < K*K; i++) begin
         win[i] = img_q[base + IDX_W'((i / K) * IMG_N + (i % K))];
      end
   end

   conv_window_mac #(
      .K        (K),
      .W_BITS   (W_BITS),
      .OUT_BITS (OUT_BITS),
      .RELU     (RELU)
   ) u_mac (
      .win     (win),
      .weights (ker_q),
      .sum     (mac_sum)
   );

   always_comb begin
      state_d = state_q;
      img_d   = img_q;
      ker_d   = ker_q;
      row_d   = row_q;
      col_d   = col_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               img_d   = image_in;
               ker_d   = kernel_in;
               row_d   = '0;
               col_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            data_d  = mac_sum;
            valid_d = 1'b1;
            last_d  = sel_is_last;
            state_d = OUT;
         end
         OUT: begin
            if (out_ready) begin
               if (last_q) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  state_d = DONE;
               end else begin
                  row_d  = adv_row;
                  col_d  = adv_col;
                  data_d = mac_sum;
                  last_d = sel_is_last;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         img_q   <= '0;
         ker_q   <= '0;
         row_q   <= '0;
         col_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         img_q   <= img_d;
         ker_q   <= ker_d;
         row_q   <= row_d;
         col_q   <= col_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_row   = row_q;
   assign out_col   = col_q;
   assign out_last  = last_q;
endmodule

// File: tb/tb_conv_stream_engine.sv
// tb/tb_conv_stream_engine.sv - directed bench for conv_stream_engine (ReLU and non-ReLU instances)
module tb_conv_stream_engine;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, out_ready;
   logic [35:0] image_in, kernel_in;
   logic        busy, out_valid, out_last, done;
   logic signed [7:0] out_data;
   logic [2:0]  out_row, out_col;
   logic        busy_r0, out_valid_r0, out_last_r0, done_r0;
   logic signed [7:0] out_data_r0;
   logic [2:0]  out_row_r0, out_col_r0;

   int n_err = 0;
   int n_chk = 0;
   int edges = 0;
   int exp_q[16];

   always @(posedge clk) edges <= edges + 1;

   conv_stream_engine #(.RELU(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .image_in(image_in), .kernel_in(kernel_in),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row(out_row), .out_col(out_col), .out_last(out_last), .done(done)
   );

   conv_stream_engine #(.RELU(0)) dut_r0 (
      .clk(clk), .rst_n(rst_n), .start(start), .image_in(image_in), .kernel_in(kernel_in),
      .busy(busy_r0), .out_valid(out_valid_r0), .out_ready(out_ready), .out_data(out_data_r0),
      .out_row(out_row_r0), .out_col(out_col_r0), .out_last(out_last_r0), .done(done_r0)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int model(input logic [35:0] img, input logic [35:0] ker, input int r, input int c);
      int s = 0;
      logic signed [3:0] w;
      for (int kr = 0; kr < 3; kr++) begin
         for (int kc = 0; kc < 3; kc++) begin
            w = ker[(kr*3+kc)*4 +: 4];
            if (img[(r+kr)*6 + c + kc]) s += int'(w);
         end
      end
      return (s < 0) ? 0 : s;
   endfunction

   task automatic fill_model(input logic [35:0] img, input logic [35:0] ker);
      for (int i = 0; i < 16; i++) exp_q[i] = model(img, ker, i / 4, i % 4);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_data"},  out_data, 0);
      chk({tag, "_row"},   out_row, 0);
      chk({tag, "_col"},   out_col, 0);
      chk({tag, "_last"},  out_last, 0);
      chk({tag, "_done"},  done, 0);
   endtask

   task automatic run_job(input logic [35:0] img, input logic [35:0] ker, input bit rand_rdy,
                          input bit check_r0, input bit inject, input int abort_at);
      int t0, n, stalls, hd, hr, hc;
      bit held, seen, rdy;
      @(negedge clk);
      image_in = img; kernel_in = ker; start = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      t0 = edges;
      chk("busy_at_T", busy, 1);
      n = 0; stalls = 0; held = 0; seen = 0; hd = 0; hr = 0; hc = 0;
      for (int cyc = 0; cyc < 300 && n < 16; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (abort_at > 0 && n == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk_reset_outputs("abort");
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (cyc == 0) chk("valid_before_T1", out_valid, 0);
         if (out_valid && !seen) begin
            seen = 1;
            chk("first_valid_edge", edges - t0, 1);
         end
         if (held) begin
            chk("hold_data", out_data, hd);
            chk("hold_row", out_row, hr);
            chk("hold_col", out_col, hc);
         end
         rdy = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
         out_ready = rdy;
         held = 0;
         if (out_valid) begin
            if (rdy) begin
               chk("row", out_row, n / 4);
               chk("col", out_col, n % 4);
               chk("data", out_data, exp_q[n]);
               chk("last", out_last, (n == 15) ? 1 : 0);
               if (check_r0) chk("data_relu0", out_data_r0, -72);
               n++;
               if (n == 16) chk("last_hs_edge", edges + 1 - t0, 17 + stalls);
            end else begin
               held = 1; hd = out_data; hr = out_row; hc = out_col;
               stalls++;
            end
         end
         if (inject && n == 4 && rdy) begin
            start = 1'b1;
            image_in = ~img;
            kernel_in = 36'h888888888;
         end
      end
      if (n < 16) chk("stream_count", n, 16);
      @(negedge clk);
      out_ready = 1'b0;
      chk("done_pulse", done, 1);
      chk("done_edge", edges - t0, 17 + stalls);
      chk("valid_after_last", out_valid, 0);
      chk("last_after_last", out_last, 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", busy, 0);
   endtask

   logic [35:0] cb, ri, rk;

   initial begin
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; image_in = '0; kernel_in = '0;
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) exp_q[i] = 9;
      run_job(36'hFFFFFFFFF, 36'h111111111, 0, 0, 0, 0);

      cb = '0;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++) cb[r*6+c] = 1'((r + c) % 2);
      for (int i = 0; i < 16; i++) exp_q[i] = ((i / 4) + (i % 4)) % 2;
      run_job(cb, 36'h000010000, 0, 0, 0, 0);

      for (int i = 0; i < 16; i++) exp_q[i] = 0;
      run_job(36'hFFFFFFFFF, 36'h888888888, 0, 1, 0, 0);

      ri = 36'({$urandom(), $urandom()});
      rk = 36'({$urandom(), $urandom()});
      fill_model(ri, rk);
      run_job(ri, rk, 1, 0, 0, 0);

      for (int i = 0; i < 16; i++) exp_q[i] = 9;
      run_job(36'hFFFFFFFFF, 36'h111111111, 0, 0, 1, 0);

      run_job(36'hFFFFFFFFF, 36'h111111111, 0, 0, 0, 5);

      ri = 36'({$urandom(), $urandom()});
      rk = 36'({$urandom(), $urandom()});
      fill_model(ri, rk);
      run_job(ri, rk, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
